// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FIFO pointer/flag controller.
package fifo_pkg;

  localparam int PTR_W_MAX = 16;

  typedef logic [PTR_W_MAX-1:0] ptr_t;

  // Encoding is {push_ok, pop_ok}.
  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_t;

  // Advances a pointer by one when en is set, wrapping at 2**addr_width.
  function automatic ptr_t next_ptr(input ptr_t ptr, input logic en,
                                    input int unsigned addr_width);
    ptr_t mask;
    mask = ptr_t'((32'd1 << addr_width) - 32'd1);
    return en ? ((ptr + ptr_t'(1)) & mask) : ptr;
  endfunction

endpackage

// File: rtl/fifo_ctrl_if.sv
// Request/status bundle between a FIFO user (master) and the pointer controller (slave).
interface fifo_ctrl_if #(
  parameter int ADDR_WIDTH = 2
);
  logic                  wr;
  logic                  rd;
  logic                  w_en;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH:0]   count;
  logic                  empty;
  logic                  full;
  logic                  almost_empty;
  logic                  almost_full;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output wr, rd,
    input  w_en, w_addr, r_addr, count, empty, full,
           almost_empty, almost_full, overflow, underflow
  );

  modport slave (
    input  wr, rd,
    output w_en, w_addr, r_addr, count, empty, full,
           almost_empty, almost_full, overflow, underflow
  );
endinterface

// File: rtl/register_file.sv
// Simple storage array: synchronous write, asynchronous read.
module register_file #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  w_en,
  input  logic [ADDR_WIDTH-1:0] w_addr,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic [ADDR_WIDTH-1:0] r_addr,
  output logic [DATA_WIDTH-1:0] r_data
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // NOTE: the array has no reset; the controller's pointers define which
  // entries are valid, so clearing storage would only cost logic.
  always_ff @(posedge clk) begin
    if (w_en) mem[w_addr] <= w_data;
  end

  assign r_data = mem[r_addr];
endmodule

// File: rtl/fifo_ctrl.sv
// Pointer and flag controller turning a register_file into a synchronous FIFO.
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 2,
  parameter int AF_THRESH  = 3,
  parameter int AE_THRESH  = 1
) (
  input  logic        clk,
  input  logic        reset,
  fifo_ctrl_if.slave  bus
);
  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic             push_ok;
  logic             pop_ok;
  fifo_op_t         op;
  logic [CNT_W-1:0] count_next;
  logic [ADDR_WIDTH-1:0] w_addr_next;
  logic [ADDR_WIDTH-1:0] r_addr_next;

  // Acceptance uses the registered flags; a full FIFO still takes a push
  // when a pop frees the head slot on the same edge.
  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    push_ok     = bus.wr & (~bus.full | bus.rd);
    pop_ok      = bus.rd & ~bus.empty;
    op          = fifo_op_t'({push_ok, pop_ok});
    count_next  = bus.count;
    w_addr_next = ADDR_WIDTH'(next_ptr(ptr_t'(bus.w_addr), push_ok, ADDR_WIDTH));
    r_addr_next = ADDR_WIDTH'(next_ptr(ptr_t'(bus.r_addr), pop_ok, ADDR_WIDTH));
    case (op)
      OP_PUSH: count_next = bus.count + CNT_W'(1);
      OP_POP:  count_next = bus.count - CNT_W'(1);
      default: count_next = bus.count;
    endcase
  end

  // Writes are suppressed while reset is held so storage is untouched.
  assign bus.w_en = push_ok & ~reset;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.w_addr       <= '0;
      bus.r_addr       <= '0;
      bus.count        <= '0;
      bus.empty        <= 1'b1;
      bus.full         <= 1'b0;
      bus.almost_empty <= 1'b1;
      bus.almost_full  <= 1'b0;
      bus.overflow     <= 1'b0;
      bus.underflow    <= 1'b0;
    end else begin
      bus.w_addr       <= w_addr_next;
      bus.r_addr       <= r_addr_next;
      bus.count        <= count_next;
      bus.empty        <= (count_next == '0);
      bus.full         <= (count_next == CNT_W'(DEPTH));
      bus.almost_empty <= (count_next <= CNT_W'(AE_THRESH));
      bus.almost_full  <= (count_next >= CNT_W'(AF_THRESH));
      bus.overflow     <= bus.wr & ~push_ok;
      bus.underflow    <= bus.rd & ~pop_ok;
    end
  end
endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench: fifo_ctrl driving a register_file, with a data scoreboard.
module tb_fifo_ctrl;
  localparam int AW    = 2;
  localparam int DEPTH = 4;
  localparam int AF    = 3;
  localparam int AE    = 1;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] w_data;
  logic [7:0] r_data;

  fifo_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

  fifo_ctrl #(.ADDR_WIDTH(AW), .AF_THRESH(AF), .AE_THRESH(AE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  register_file #(.ADDR_WIDTH(AW), .DATA_WIDTH(8)) rf (
    .clk    (clk),
    .w_en   (bus.w_en),
    .w_addr (bus.w_addr),
    .w_data (w_data),
    .r_addr (bus.r_addr),
    .r_data (r_data)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  int         m_cnt, m_wp, m_rp;
  logic       m_ov, m_uf;
  logic [7:0] sb [$];
  int         wraps_seen, wraps_exp;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_state();
    check("count", 32'(bus.count), 32'(m_cnt));
    check("empty", 32'(bus.empty), 32'(m_cnt == 0));
    check("full", 32'(bus.full), 32'(m_cnt == DEPTH));
    check("almost_empty", 32'(bus.almost_empty), 32'(m_cnt <= AE));
    check("almost_full", 32'(bus.almost_full), 32'(m_cnt >= AF));
    check("overflow", 32'(bus.overflow), 32'(m_ov));
    check("underflow", 32'(bus.underflow), 32'(m_uf));
    check("w_addr", 32'(bus.w_addr), 32'(m_wp));
    check("r_addr", 32'(bus.r_addr), 32'(m_rp));
    if (m_cnt != 0) check("r_data_head", 32'(r_data), 32'(sb[0]));
  endtask

  // One clock of stimulus: drive, check acceptance and head, clock, check state.
  task automatic cycle(input logic w, input logic r, input logic [7:0] d);
    logic p_ok, q_ok;
    logic [AW-1:0] prev_wa;
    bus.wr = w;
    bus.rd = r;
    w_data = d;
    #1;
    p_ok = w && ((m_cnt != DEPTH) || r);
    q_ok = r && (m_cnt != 0);
    check("w_en", 32'(bus.w_en), 32'(p_ok));
    if (q_ok) begin
      check("pop_data", 32'(r_data), 32'(sb[0]));
      void'(sb.pop_front());
    end
    if (p_ok) sb.push_back(d);
    prev_wa = bus.w_addr;
    @(posedge clk);
    #1;
    if (p_ok) begin
      if (m_wp == DEPTH - 1) wraps_exp++;
      m_wp = (m_wp + 1) % DEPTH;
    end
    if (q_ok) m_rp = (m_rp + 1) % DEPTH;
    m_cnt = m_cnt + (p_ok ? 1 : 0) - (q_ok ? 1 : 0);
    m_ov  = w & ~p_ok;
    m_uf  = r & ~q_ok;
    if (prev_wa == AW'(DEPTH - 1) && bus.w_addr == '0) wraps_seen++;
    check_state();
  endtask

  task automatic model_reset();
    m_cnt = 0; m_wp = 0; m_rp = 0; m_ov = 1'b0; m_uf = 1'b0;
    sb.delete();
  endtask

  initial begin
    reset  = 1'b1;
    bus.wr = 1'b1;
    bus.rd = 1'b1;
    w_data = 8'h77;
    model_reset();

    // Scenario 1: reset held two cycles with wr = rd = 1
    repeat (2) begin
      @(posedge clk);
      #1;
      check("rst_w_en", 32'(bus.w_en), 32'd0);
      check_state();
    end
    reset  = 1'b0;
    bus.wr = 1'b0;
    bus.rd = 1'b0;
    @(posedge clk);
    #1;
    check_state();

    // Scenario 2: fill
    cycle(1'b1, 1'b0, 8'hFF);
    cycle(1'b1, 1'b0, 8'hEE);
    cycle(1'b1, 1'b0, 8'hDD);
    cycle(1'b1, 1'b0, 8'hCC);

    // Scenario 3: overflow, then drain
    cycle(1'b1, 1'b0, 8'hBB);
    cycle(1'b0, 1'b0, 8'h00);
    repeat (4) cycle(1'b0, 1'b1, 8'h00);
    cycle(1'b0, 1'b0, 8'h00);

    // Scenario 4: simultaneous push/pop from empty
    cycle(1'b1, 1'b1, 8'h5A);
    cycle(1'b0, 1'b1, 8'h00);
    cycle(1'b0, 1'b1, 8'h00);
    cycle(1'b0, 1'b0, 8'h00);

    // Scenario 5: simultaneous push/pop while full
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 8'(8'h10 + i));
    cycle(1'b1, 1'b1, 8'h20);
    repeat (4) cycle(1'b0, 1'b1, 8'h00);

    // Scenario 6: wrap with push/pop pairs
    wraps_seen = 0;
    wraps_exp  = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b0, 8'(i));
      cycle(1'b0, 1'b1, 8'h00);
    end
    check("w_wraps", 32'(wraps_seen), 32'(wraps_exp));
    check("final_count", 32'(bus.count), 32'd0);

    // Mid-operation reset discards contents
    cycle(1'b1, 1'b0, 8'hA1);
    cycle(1'b1, 1'b0, 8'hA2);
    reset = 1'b1;
    bus.wr = 1'b0;
    bus.rd = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    check_state();
    cycle(1'b1, 1'b0, 8'h3C);
    cycle(1'b0, 1'b1, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
- Pointer and flag controller that turns a register_file instance into a synchronous FIFO.
- Sits directly upstream of the register file: accepts push/pop requests and drives the storage's w_en, w_addr and r_addr.
- r_data is taken straight from the register file's asynchronous read port, so the FIFO head is always visible without a read cycle.
- Exposes full, empty, almost-full, almost-empty, an occupancy count, and overflow/underflow error pulses.

Parameters:
- ADDR_WIDTH, 2: pointer width. Depth DEPTH = 2**ADDR_WIDTH entries. Must match the register file's ADDR_WIDTH.
- AF_THRESH, 3: almost_full asserts when count >= AF_THRESH. Legal range 1..DEPTH.
- AE_THRESH, 1: almost_empty asserts when count <= AE_THRESH. Legal range 0..DEPTH-1.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- wr  input  1  push request; the data is on the register file's w_data this cycle
- rd  input  1  pop request; consumes the entry currently at r_addr
- w_en  output  1  write enable to the register file (combinational)
- w_addr  output  ADDR_WIDTH  write pointer (registered)
- r_addr  output  ADDR_WIDTH  read pointer, i.e. the head entry (registered)
- count  output  ADDR_WIDTH+1  occupancy, 0..DEPTH (registered)
- empty  output  1  count == 0 (registered)
- full  output  1  count == DEPTH (registered)
- almost_empty  output  1  count <= AE_THRESH (registered)
- almost_full  output  1  count >= AF_THRESH (registered)
- overflow  output  1  one-cycle pulse: a push was rejected on the previous edge
- underflow  output  1  one-cycle pulse: a pop was rejected on the previous edge

Behaviour:
- Reset (synchronous, takes priority over everything):
  - w_addr = 0, r_addr = 0, count = 0
  - empty = 1, full = 0, almost_empty = 1, almost_full = 0 (when AF_THRESH >= 1)
  - overflow = 0, underflow = 0
- Acceptance rules, evaluated on the current registered flags:
  - push_ok = wr & (~full | rd)
  - pop_ok = rd & ~empty
- w_en = push_ok, driven combinationally; the register file captures w_data at the same edge.
- Pointer update at each rising edge:
  - push_ok: w_addr <= w_addr + 1, modulo DEPTH (wraps DEPTH-1 -> 0)
  - pop_ok: r_addr <= r_addr + 1, modulo DEPTH
- Count update:
  - push only: +1
  - pop only: -1
  - both or neither: unchanged
- Flags are computed from the next count and registered, so they change on the same edge as count. There is no extra latency.
- Full with wr & rd: both accepted. The head is popped and the new entry is written into the freed slot in the same edge. Count stays DEPTH; full stays 1.
- Empty with wr & rd: only the push is accepted; the pop is rejected (no bypass). Count becomes 1; underflow pulses next cycle.
- wr while full and rd = 0: rejected. w_en = 0, pointers unchanged, overflow pulses next cycle.
- rd while empty: rejected. r_addr unchanged, underflow pulses next cycle.
- overflow <= wr & ~push_ok; underflow <= rd & ~pop_ok. Each is high for exactly one cycle per rejected request.
- Reset asserted mid-operation discards all contents logically: pointers return to 0 and flags return to their reset values. Register file contents are not cleared and are not observable until rewritten.
- Pointers never exceed DEPTH-1, and count never exceeds DEPTH under any input sequence.
- r_data is meaningful only when empty = 0.

Decomposition:
- fifo_pkg holds:
  - typedef enum logic [1:0] fifo_op_t {OP_NONE, OP_PUSH, OP_POP, OP_BOTH}, encoding {push_ok, pop_ok}
  - function next_ptr(ptr, en) for increment with wrap
- No sub-module is needed: one always_ff for pointers, count, flags and error pulses, and one always_comb for acceptance.
- A top-level wrapper fifo (fifo_ctrl + register_file) is the integration target for the bench.

Test Plan:
- Parameters: ADDR_WIDTH = 2, AF_THRESH = 3, AE_THRESH = 1.
- Scenario 1, reset: hold reset for 2 cycles with wr = rd = 1.
  -> count = 0, empty = 1, full = 0, almost_empty = 1, w_en = 0 during reset; no overflow or underflow pulse after release.
- Scenario 2, fill: push 0xFF, 0xEE, 0xDD, 0xCC.
  -> count goes 1, 2, 3, 4; almost_empty drops after the 2nd push; almost_full rises after the 3rd; full rises after the 4th; r_data = 0xFF throughout.
- Scenario 3, overflow: push 0xBB while full.
  -> w_en = 0, count stays 4, overflow = 1 for exactly one cycle; then pop 4 times to read 0xFF, 0xEE, 0xDD, 0xCC; empty = 1; 0xBB never appears.
- Scenario 4, empty read/write: from empty, assert wr = rd = 1 with w_data = 0x5A.
  -> count = 1, underflow pulses once, r_data = 0x5A; then rd alone -> empty = 1, and one more rd -> underflow pulses again.
- Scenario 5, full read/write: fill with 0x10..0x13, then assert wr = rd = 1 with w_data = 0x20.
  -> count stays 4, full stays 1, no overflow; draining reads 0x11, 0x12, 0x13, 0x20.
- Scenario 6, wrap: run 10 push/pop pairs with values 0x00..0x09.
  -> data returns in order, w_addr and r_addr wrap 3 -> 0 at least twice, and count ends at 0.
